// File: rtl/charging_cnt_poller.sv
// charging_cnt_poller: sweeps a contiguous range of counter IDs over the
// charging block's counter-table port. Each entry is read and presented on a
// report stream. When the build enables it, each entry can also be zeroed
// after it has been reported.
//
// Build option: define CHARGING_POLL_CLEAR_EN to compile in the clear-on-read
// path (CLR state, w_cnt_* drive). Without it, clear_on_read is ignored and
// w_cnt_* are tied to zero.
//
// Ports:
//   asclk, aresetn        clock, synchronous active-low reset
//   start, first_id,      sweep request; sampled in IDLE only
//   last_id, clear_on_read
//   busy, done,           status: busy outside IDLE, one-cycle done pulse,
//   err_timeout           sticky read-timeout flag
//   r_cnt_*               read request channel and read data return
//   w_cnt_*               write (clear) request channel, data always zero
//   rpt_*                 report stream (valid/ready)
module charging_cnt_poller #(
  parameter int unsigned ID_W    = 14,
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              asclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic [ID_W-1:0]   first_id,
  input  logic [ID_W-1:0]   last_id,
  input  logic              clear_on_read,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic [ID_W-1:0]   r_cnt_id,
  output logic              r_cnt_vld,
  input  logic              r_cnt_rdy,
  input  logic              r_cnt_data_vld,
  input  logic [DATA_W-1:0] r_cnt_data,
  output logic [ID_W-1:0]   w_cnt_id,
  output logic              w_cnt_vld,
  output logic [DATA_W-1:0] w_cnt_data,
  input  logic              w_cnt_rdy,
  output logic              rpt_vld,
  output logic [ID_W-1:0]   rpt_id,
  output logic [DATA_W-1:0] rpt_data,
  input  logic              rpt_rdy
);

  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    RPT,
`ifdef CHARGING_POLL_CLEAR_EN
    CLR,
`endif
    DONE
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   cur;
  logic [ID_W-1:0]   last_q;
  logic [WAIT_W-1:0] wait_cnt;

  // Clears always write zero.
  assign w_cnt_data = '0;

`ifdef CHARGING_POLL_CLEAR_EN
  logic clr_q;
`else
  // Clear path compiled out: write channel idle, clear inputs unused.
  logic unused_clr;
  assign unused_clr = ^{clear_on_read, w_cnt_rdy};
  assign w_cnt_vld  = 1'b0;
  assign w_cnt_id   = '0;
`endif

  // Sweep sequencer. The end test compares cur to last_q before incrementing,
  // so a range ending at the all-ones ID terminates without wrapping.
  always_ff @(posedge asclk) begin
    if (!aresetn) begin
      state       <= IDLE;
      cur         <= '0;
      last_q      <= '0;
      wait_cnt    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      r_cnt_vld   <= 1'b0;
      r_cnt_id    <= '0;
      rpt_vld     <= 1'b0;
      rpt_id      <= '0;
      rpt_data    <= '0;
`ifdef CHARGING_POLL_CLEAR_EN
      clr_q       <= 1'b0;
      w_cnt_vld   <= 1'b0;
      w_cnt_id    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            err_timeout <= 1'b0;
            last_q      <= last_id;
            cur         <= first_id;
            busy        <= 1'b1;
`ifdef CHARGING_POLL_CLEAR_EN
            clr_q       <= clear_on_read;
`endif
            if (first_id <= last_id) begin
              r_cnt_vld <= 1'b1;
              r_cnt_id  <= first_id;
              state     <= RD_REQ;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        RD_REQ: begin
          if (r_cnt_rdy) begin
            r_cnt_vld <= 1'b0;
            wait_cnt  <= '0;
            state     <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (r_cnt_data_vld) begin
            rpt_data <= r_cnt_data;
            rpt_id   <= cur;
            rpt_vld  <= 1'b1;
            state    <= RPT;
          end else if (wait_cnt == WAIT_LAST) begin
            err_timeout <= 1'b1;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        RPT: begin
          if (rpt_rdy) begin
            rpt_vld <= 1'b0;
`ifdef CHARGING_POLL_CLEAR_EN
            if (clr_q) begin
              w_cnt_vld <= 1'b1;
              w_cnt_id  <= cur;
              state     <= CLR;
            end else
`endif
            if (cur == last_q) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              cur       <= cur + ID_W'(1);
              r_cnt_id  <= cur + ID_W'(1);
              r_cnt_vld <= 1'b1;
              state     <= RD_REQ;
            end
          end
        end
`ifdef CHARGING_POLL_CLEAR_EN
        CLR: begin
          if (w_cnt_rdy) begin
            w_cnt_vld <= 1'b0;
            if (cur == last_q) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              cur       <= cur + ID_W'(1);
              r_cnt_id  <= cur + ID_W'(1);
              r_cnt_vld <= 1'b1;
              state     <= RD_REQ;
            end
          end
        end
`endif
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_charging_cnt_poller.sv
// Bench for charging_cnt_poller: a randomized counter-table slave, a
// scoreboard fed by a spec-level sweep model, and a monitor that checks
// reports, writes, done pulses and handshake stability.
module tb_charging_cnt_poller;

  localparam int unsigned ID_W    = 14;
  localparam int unsigned DATA_W  = 512;
  localparam int unsigned TIMEOUT = 64;
  localparam int          MAX_ID  = (1 << ID_W) - 1;
`ifdef CHARGING_POLL_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic              asclk = 1'b0;
  logic              aresetn;
  logic              start;
  logic [ID_W-1:0]   first_id, last_id;
  logic              clear_on_read;
  logic              busy, done, err_timeout;
  logic [ID_W-1:0]   r_cnt_id, w_cnt_id, rpt_id;
  logic              r_cnt_vld, r_cnt_rdy, r_cnt_data_vld;
  logic [DATA_W-1:0] r_cnt_data, w_cnt_data, rpt_data;
  logic              w_cnt_vld, w_cnt_rdy;
  logic              rpt_vld, rpt_rdy;

  charging_cnt_poller #(.ID_W(ID_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .asclk(asclk), .aresetn(aresetn), .start(start), .first_id(first_id),
    .last_id(last_id), .clear_on_read(clear_on_read), .busy(busy), .done(done),
    .err_timeout(err_timeout), .r_cnt_id(r_cnt_id), .r_cnt_vld(r_cnt_vld),
    .r_cnt_rdy(r_cnt_rdy), .r_cnt_data_vld(r_cnt_data_vld), .r_cnt_data(r_cnt_data),
    .w_cnt_id(w_cnt_id), .w_cnt_vld(w_cnt_vld), .w_cnt_data(w_cnt_data),
    .w_cnt_rdy(w_cnt_rdy), .rpt_vld(rpt_vld), .rpt_id(rpt_id), .rpt_data(rpt_data),
    .rpt_rdy(rpt_rdy)
  );

  always #5 asclk = ~asclk;

  int cyc = 0;
  always @(posedge asclk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic flag(input string name, input int act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got %0d expected none (t=%0t)", name, act, $time);
  endtask

  // Stimulus data: ID*3 in the low bits, salted by a per-sweep seed.
  int unsigned seed = 0;
  function automatic logic [DATA_W-1:0] base_val(input int id);
    return (DATA_W'(seed) << 256) | DATA_W'(id * 3);
  endfunction

  // Scoreboard queues.
  typedef struct {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } rpt_t;
  rpt_t exp_rpt[$];
  int   exp_wr[$];
  bit   exp_done[$];
  int   n_done = 0;

  // Slave and ready drivers.
  bit slv_cleared [0:MAX_ID];
  bit mdl_cleared [0:MAX_ID];
  int lat = 3;
  bit slave_mute = 0;
  bit rrdy_rand = 0;
  bit wrdy_rand = 1;
  int rpt_mode = 0;
  bit stray_req = 0;
  int hs_cyc = 0;

  initial begin
    bit hs_r, hs_w, rv, rhs, rst_s, pend;
    int rid, wid, pid, remain, hold;
    pend = 0; remain = 0; hold = 0; pid = 0;
    r_cnt_rdy = 0; r_cnt_data_vld = 0; r_cnt_data = '0; w_cnt_rdy = 0; rpt_rdy = 0;
    forever begin
      @(negedge asclk);
      hs_r  = r_cnt_vld && r_cnt_rdy;
      hs_w  = w_cnt_vld && w_cnt_rdy;
      rid   = int'(r_cnt_id);
      wid   = int'(w_cnt_id);
      rv    = rpt_vld;
      rhs   = rpt_vld && rpt_rdy;
      rst_s = !aresetn;
      if (hs_r) hs_cyc = cyc;
      @(posedge asclk);
      #1;
      r_cnt_data_vld = 1'b0;
      if (hs_w) slv_cleared[wid] = 1'b1;
      if (rst_s) pend = 0;
      else if (hs_r) begin
        pend = !slave_mute;
        remain = lat;
        pid = rid;
      end
      if (pend) begin
        remain--;
        if (remain == 0) begin
          r_cnt_data_vld = 1'b1;
          r_cnt_data = slv_cleared[pid] ? '0 : base_val(pid);
          pend = 0;
        end
      end
      if (stray_req) begin
        r_cnt_data_vld = 1'b1;
        r_cnt_data = {16{32'hdeadbeef}};
        stray_req = 0;
      end
      r_cnt_rdy = rrdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      w_cnt_rdy = wrdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      case (rpt_mode)
        0: rpt_rdy = 1'b1;
        1: rpt_rdy = ($urandom_range(0, 2) == 0);
        2: begin
          if (rhs) hold = 0;
          else if (rv) hold++;
          rpt_rdy = (hold >= 10);
        end
        default: rpt_rdy = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on handshakes and checks hold-while-valid.
  bit prev_rstn = 0, prev_rvld = 0, prev_rrdy = 0, prev_pvld = 0, prev_prdy = 0, prev_done = 0;
  logic [ID_W-1:0]   prev_rid, prev_pid;
  logic [DATA_W-1:0] prev_pdata;
  initial begin
    rpt_t e;
    bit   eb;
    forever begin
      @(negedge asclk);
      if (prev_rstn && prev_rvld && !prev_rrdy) begin
        chk("r_vld_hold", r_cnt_vld, 1);
        chk("r_id_hold", r_cnt_id, prev_rid);
      end
      if (prev_rstn && prev_pvld && !prev_prdy) begin
        chk("rpt_vld_hold", rpt_vld, 1);
        chk("rpt_id_hold", rpt_id, prev_pid);
        chk("rpt_data_hold", rpt_data, prev_pdata);
      end
      if (prev_rstn && aresetn && prev_done) begin
        chk("done_width", done, 0);
        chk("busy_after_done", busy, 0);
      end
      if (rpt_vld && rpt_rdy) begin
        if (exp_rpt.size() == 0) flag("rpt_unexpected", int'(rpt_id));
        else begin
          e = exp_rpt.pop_front();
          chk("rpt_id", rpt_id, e.id);
          chk("rpt_data", rpt_data, e.data);
        end
      end
      if (w_cnt_vld) begin
        chk("rd_wr_overlap", r_cnt_vld, 0);
        if (exp_wr.size() == 0) flag("w_unexpected", int'(w_cnt_id));
        else if (w_cnt_rdy) begin
          chk("w_id", w_cnt_id, exp_wr.pop_front());
          chk("w_data", w_cnt_data, 0);
        end
      end
      if (done) begin
        n_done++;
        if (exp_done.size() == 0) flag("done_unexpected", 1);
        else begin
          eb = exp_done.pop_front();
          chk("err_timeout", err_timeout, eb);
          chk("busy_at_done", busy, 1);
          if (eb) chk_range("timeout_latency", cyc - hs_cyc, TIMEOUT, TIMEOUT + 1);
        end
      end
      prev_rstn = aresetn;
      prev_rvld = r_cnt_vld; prev_rrdy = r_cnt_rdy; prev_rid = r_cnt_id;
      prev_pvld = rpt_vld;   prev_prdy = rpt_rdy;   prev_pid = rpt_id; prev_pdata = rpt_data;
      prev_done = done;
    end
  end

  task automatic apply_reset(input int cycles);
    @(posedge asclk); #1;
    aresetn = 0;
    repeat (cycles) @(posedge asclk);
    #1;
    aresetn = 1;
    exp_rpt.delete(); exp_wr.delete(); exp_done.delete();
  endtask

  // Predict a sweep from the rules, launch it, and wait for its done pulse.
  task automatic sweep(input int f, input int l, input bit clr);
    int base;
    if (f <= l) begin
      if (slave_mute) exp_done.push_back(1'b1);
      else begin
        for (int id = f; id <= l; id++) begin
          exp_rpt.push_back('{id: ID_W'(id), data: mdl_cleared[id] ? '0 : base_val(id)});
          if (CLEAR_EN && clr) begin
            exp_wr.push_back(id);
            mdl_cleared[id] = 1'b1;
          end
        end
        exp_done.push_back(1'b0);
      end
    end else exp_done.push_back(1'b0);
    base = n_done;
    @(posedge asclk); #1;
    start = 1; first_id = ID_W'(f); last_id = ID_W'(l); clear_on_read = clr;
    @(posedge asclk); #1;
    start = 0; first_id = ID_W'($urandom); last_id = ID_W'($urandom); clear_on_read = ~clr;
    @(negedge asclk);
    chk("err_cleared_on_start", err_timeout, 0);
    if (f <= l) chk("start_to_rvld", r_cnt_vld, 1);
    else begin
      chk("empty_done", done, 1);
      chk("empty_no_read", r_cnt_vld, 0);
    end
    for (int i = 0; i < 3000 && n_done == base; i++) @(negedge asclk);
    if (n_done == base) begin
      flag("sweep_no_done", f);
      apply_reset(2);
    end
    repeat (2) @(negedge asclk);
    chk("rpt_left", exp_rpt.size(), 0);
    chk("wr_left", exp_wr.size(), 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int f, l, base;
    aresetn = 0; start = 0; first_id = '0; last_id = '0; clear_on_read = 0;
    repeat (3) @(posedge asclk);
    @(negedge asclk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_rvld", r_cnt_vld, 0);
    chk("rst_rid", r_cnt_id, 0);
    chk("rst_wvld", w_cnt_vld, 0);
    chk("rst_wid", w_cnt_id, 0);
    chk("rst_pvld", rpt_vld, 0);
    chk("rst_pdata", rpt_data, 0);
    @(posedge asclk); #1;
    aresetn = 1;

    // Basic sweep: data = ID*3, latency 3, always ready.
    seed = 0; lat = 3; rrdy_rand = 0; wrdy_rand = 0; rpt_mode = 0;
    sweep(5, 7, 0);

    // Clear-on-read, then read back.
    wrdy_rand = 1;
    sweep(100, 100, 1);
    sweep(100, 100, 0);

    // Backpressure on reports, random read/write ready.
    seed = $urandom; rpt_mode = 2; rrdy_rand = 1;
    sweep(300, 305, 1);
    rpt_mode = 1;
    sweep(400, 404, 0);

    // Read timeout, then a clean sweep clears the flag.
    rpt_mode = 0; rrdy_rand = 0; slave_mute = 1;
    sweep(40, 45, 0);
    chk("err_sticky", err_timeout, 1);
    slave_mute = 0;
    sweep(40, 40, 0);

    // Edge IDs.
    sweep(MAX_ID - 1, MAX_ID, 0);
    sweep(9, 3, 0);

    // Reset while a report is pending.
    rpt_mode = 3;
    @(posedge asclk); #1;
    start = 1; first_id = 14'd200; last_id = 14'd203; clear_on_read = 0;
    @(posedge asclk); #1;
    start = 0;
    for (int i = 0; i < 200 && !rpt_vld; i++) @(negedge asclk);
    chk("reached_rpt", rpt_vld, 1);
    base = n_done;
    @(posedge asclk); #1;
    aresetn = 0;
    @(posedge asclk);
    @(negedge asclk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rvld", r_cnt_vld, 0);
    chk("abort_pvld", rpt_vld, 0);
    chk("abort_pid", rpt_id, 0);
    chk("abort_pdata", rpt_data, 0);
    @(posedge asclk); #1;
    aresetn = 1;
    rpt_mode = 0;
    repeat (3) @(negedge asclk);
    chk("no_done_on_reset", n_done, base);

    // Stray read data while idle.
    @(posedge asclk); #1;
    stray_req = 1;
    repeat (5) begin
      @(negedge asclk);
      chk("stray_no_rpt", rpt_vld, 0);
    end

    // Randomized sweeps.
    repeat (12) begin
      seed = $urandom; lat = $urandom_range(1, 5);
      rrdy_rand = $urandom_range(0, 1); rpt_mode = $urandom_range(0, 1);
      f = $urandom_range(0, MAX_ID);
      l = f + $urandom_range(0, 4);
      if (l > MAX_ID) l = MAX_ID;
      if (f > 0 && $urandom_range(0, 5) == 0) l = f - 1;
      sweep(f, l, $urandom_range(0, 1) == 1);
    end

    repeat (4) @(negedge asclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/charging_cnt_poller.md
# charging_cnt_poller

Host-side initiator for the counter-table management port of the charging block. It drives the `r_cnt_*` read and `w_cnt_*` write request channels to sweep a contiguous range of counter IDs. It returns each 512-bit entry on a report stream and can optionally clear each entry after reading it. It sits between the control-plane CSR logic and the charging block, and replaces ad-hoc software polling of individual counters.

## Interface
Parameters:
- ID_W, 14, counter ID width
- DATA_W, 512, counter entry width
- TIMEOUT, 64, maximum cycles to wait for `r_cnt_data_vld` after a read handshake

Ports:
- asclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- start  in  1  begin sweep; sampled only in IDLE
- first_id  in  ID_W  first ID of the sweep; sampled with start
- last_id  in  ID_W  last ID of the sweep, inclusive; sampled with start
- clear_on_read  in  1  write zero after each report; sampled with start
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse when the sweep ends
- err_timeout  out  1  sticky; set on read timeout, cleared by the next accepted start
- r_cnt_id  out  ID_W  read request ID
- r_cnt_vld  out  1  read request valid
- r_cnt_rdy  in  1  read request ready
- r_cnt_data_vld  in  1  read data valid, one-cycle pulse
- r_cnt_data  in  DATA_W  read data
- w_cnt_id  out  ID_W  write ID
- w_cnt_vld  out  1  write valid
- w_cnt_data  out  DATA_W  write data, always zero
- w_cnt_rdy  in  1  write ready
- rpt_vld  out  1  report valid
- rpt_id  out  ID_W  ID of the reported entry
- rpt_data  out  DATA_W  entry contents
- rpt_rdy  in  1  report ready

## Operation
States: IDLE, RD_REQ, RD_WAIT, RPT, CLR, DONE.
- **IDLE:** start=1 captures first_id, last_id and clear_on_read, and clears err_timeout.
  - first_id ≤ last_id: cur=first_id, go to RD_REQ.
  - first_id > last_id: go to DONE with no access.
  - start while not IDLE is ignored.
- **RD_REQ:** r_cnt_vld=1, r_cnt_id=cur. The request is held stable until r_cnt_rdy=1. On the handshake: go to RD_WAIT and zero the wait counter.
- **RD_WAIT:** wait counter increments every cycle.
  - r_cnt_data_vld=1: capture r_cnt_data into rpt_data, go to RPT.
  - Counter reaches TIMEOUT-1 with no data: set err_timeout, go to DONE.
  - r_cnt_data_vld in any other state is ignored.
- **RPT:** rpt_vld=1 with rpt_id=cur. rpt_id and rpt_data are held until rpt_rdy=1. On the handshake:
  - clear flag set: go to CLR.
  - cur==last_id: go to DONE.
  - otherwise: cur+1, go to RD_REQ.
- **CLR:** w_cnt_vld=1, w_cnt_id=cur, w_cnt_data=0. The request is held until w_cnt_rdy=1. On the handshake:
  - cur==last_id: go to DONE.
  - otherwise: cur+1, go to RD_REQ.
- **DONE:** done=1 for one cycle, then IDLE.
- **busy:** 1 in every state except IDLE.
- **ID arithmetic:** cur is ID_W bits. The end test compares against last_id before incrementing, so last_id = 2^ID_W−1 terminates without wrap.
- At most one outstanding read at any time. Reads and writes are never issued in the same cycle.

## Timing
- **Reset values:** every output is 0 and the state is IDLE.
  - Reset mid-sweep aborts the sweep immediately.
  - Outputs are 0 the cycle after aresetn is sampled low.
  - No done pulse is generated on reset.
- start accepted in cycle N: r_cnt_vld=1 in cycle N+1.
- r_cnt_data_vld in cycle M: rpt_vld=1 in cycle M+1.
- rpt handshake in cycle K:
  - clear enabled: w_cnt_vld=1 in cycle K+1.
  - no clear, more IDs remain: r_cnt_vld=1 in cycle K+1.
- Last handshake in cycle L: done=1 in cycle L+1, busy=0 in cycle L+2.
- Best-case per-entry cost with an always-ready slave (T = slave read latency in cycles): T+2 cycles without clear, T+3 with clear.

## Configuration
- **CHARGING_POLL_CLEAR_EN defined:** clear-on-read path (CLR state, w_cnt_* drive) is compiled in as described above.
- **CHARGING_POLL_CLEAR_EN undefined:**
  - CLR state is removed.
  - clear_on_read is ignored.
  - w_cnt_vld, w_cnt_id and w_cnt_data are tied to 0.
  - An RPT handshake always proceeds directly to DONE or to RD_REQ.

## Test plan
- **Basic sweep:** first_id=5, last_id=7, no clear, slave returns data=ID×3 after 3 cycles, rpt_rdy=1 → reports (5,15), (6,18), (7,21) in order; a single done pulse; zero w_cnt_vld cycles.
- **Clear-on-read:** first_id=last_id=100, clear_on_read=1 → one report, then one write with w_cnt_id=100 and data=0; done follows the write handshake; a second sweep reads back 0.
- **Backpressure:** rpt_rdy held low for 10 cycles and r_cnt_rdy toggled randomly → rpt_id, rpt_data and r_cnt_id stay stable while their valid is high; no report is lost or duplicated.
- **Timeout:** slave never asserts r_cnt_data_vld, TIMEOUT=64 → err_timeout=1 and done 64–65 cycles after the read handshake; next start clears err_timeout.
- **Edge IDs:** first_id=16382, last_id=16383 → exactly 2 reports, then terminates with no wrap. first_id=9, last_id=3 → done the cycle after start, with no r_cnt_vld.
- **Reset and stray data:** aresetn low while in RPT → all outputs 0 the next cycle and no done pulse. A stray r_cnt_data_vld while IDLE produces no report.
